// File: rtl/mdu_div_unit_pkg.sv
// rtl/mdu_div_unit_pkg.sv - shared MDU divide types, op encodings and decode helper
package mdu_div_unit_pkg;

  // MicOp_t::_mdu divide encodings
  typedef enum logic [4:0] {
    MDU_DIV   = 5'b10000,
    MDU_DIVW  = 5'b10001,
    MDU_DIVU  = 5'b10010,
    MDU_REM   = 5'b10011,
    MDU_REMW  = 5'b10100,
    MDU_REMU  = 5'b10101,
    MDU_REMUW = 5'b10110
  } mic_op_mdu_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int DIV_ITER_D = 64;
  localparam int DIV_ITER_W = 32;

  typedef struct packed {
    logic known;
    logic sgn;
    logic word;
    logic rem;
  } div_dec_t;

  // Unknown encodings decode with known=0 and complete with a zero result
  function automatic div_dec_t div_decode(input logic [4:0] op);
    div_dec_t d;
    d       = '0;
    d.known = 1'b1;
    case (op)
      MDU_DIV:   d.sgn = 1'b1;
      MDU_DIVW:  begin d.sgn = 1'b1; d.word = 1'b1; end
      MDU_DIVU:  d.rem = 1'b0;
      MDU_REM:   begin d.sgn = 1'b1; d.rem = 1'b1; end
      MDU_REMW:  begin d.sgn = 1'b1; d.word = 1'b1; d.rem = 1'b1; end
      MDU_REMU:  d.rem = 1'b1;
      MDU_REMUW: begin d.word = 1'b1; d.rem = 1'b1; end
      default:   d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_div_unit_div_restore_step.sv
// rtl/mdu_div_unit_div_restore_step.sv - one combinational restoring-division step
module div_restore_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quot_out
);

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff;

  // Shift in the next dividend bit; subtract the divisor when it fits, else restore
  always_comb begin
    shifted  = {rem_in, quot_in[XLEN-1]};
    ge       = (shifted >= {1'b0, dvsr});
    // when ge, the difference is below dvsr so the low XLEN bits are exact
    diff     = shifted[XLEN-1:0] - dvsr;
    rem_out  = ge ? diff : shifted[XLEN-1:0];
    quot_out = {quot_in[XLEN-2:0], ge};
  end

endmodule

// File: rtl/mdu_div_unit.sv
// rtl/mdu_div_unit.sv - iterative radix-2 restoring divider for MDU div/rem micro-ops
module mdu_div_unit
  import mdu_div_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [4:0]       i_micop,
  input  logic [XLEN-1:0]  i_src1,
  input  logic [XLEN-1:0]  i_src2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  div_state_t      state;
  logic [6:0]      cnt;
  logic [XLEN-1:0] rem_q, quot_q, dvsr_q;
  logic            is_word, is_rem, q_neg, r_neg;

  div_dec_t        dec;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_raw, spec_res, quot_init;
  logic            s1, s2, dvsr_zero, ovf;

  logic [XLEN-1:0] step_rem, step_quot, q_fin, r_fin, sel_res, fin_res;

  // Decode the incoming op: width-adjusted operands, magnitudes, signs and special-case result
  always_comb begin
    dec = div_decode(i_micop);
    if (dec.word) begin
      a_ext = dec.sgn ? {{(XLEN-32){i_src1[31]}}, i_src1[31:0]} : {{(XLEN-32){1'b0}}, i_src1[31:0]};
      b_ext = dec.sgn ? {{(XLEN-32){i_src2[31]}}, i_src2[31:0]} : {{(XLEN-32){1'b0}}, i_src2[31:0]};
    end else begin
      a_ext = i_src1;
      b_ext = i_src2;
    end
    s1        = dec.sgn & a_ext[XLEN-1];
    s2        = dec.sgn & b_ext[XLEN-1];
    a_mag     = s1 ? -a_ext : a_ext;
    b_mag     = s2 ? -b_ext : b_ext;
    min_val   = dec.word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    dvsr_zero = (b_ext == '0);
    ovf       = dec.sgn & (a_ext == min_val) & (b_ext == '1);
    if (!dec.known)     spec_raw = '0;
    else if (dvsr_zero) spec_raw = dec.rem ? a_ext : '1;
    else                spec_raw = dec.rem ? '0 : a_ext;
    spec_res  = dec.word ? {{(XLEN-32){spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
    // word dividends start at the top so 32 shifts leave the quotient in the low half
    quot_init = dec.word ? (a_mag << (XLEN-32)) : a_mag;
  end

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem_in   (rem_q),
    .quot_in  (quot_q),
    .dvsr     (dvsr_q),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  // Final-step fixup: apply signs, pick quotient or remainder, sign-extend word results
  always_comb begin
    q_fin   = q_neg ? -step_quot : step_quot;
    r_fin   = r_neg ? -step_rem : step_rem;
    sel_res = is_rem ? r_fin : q_fin;
    fin_res = is_word ? {{(XLEN-32){sel_res[31]}}, sel_res[31:0]} : sel_res;
  end

  // Divider FSM with registered handshake and result outputs; flush beats everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      is_word  <= 1'b0;
      is_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      o_rdy    <= 1'b1;
      o_vld    <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
    end else if (i_flush) begin
      state <= IDLE;
      cnt   <= '0;
      o_vld <= 1'b0;
      o_rdy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_vld) begin
            o_rdy   <= 1'b0;
            o_tag   <= i_tag;
            is_word <= dec.word;
            is_rem  <= dec.rem;
            q_neg   <= s1 ^ s2;
            r_neg   <= s1;
            rem_q   <= '0;
            quot_q  <= quot_init;
            dvsr_q  <= b_mag;
            if (!dec.known || dvsr_zero || ovf) begin
              state    <= DONE;
              o_vld    <= 1'b1;
              o_result <= spec_res;
            end else begin
              state <= CALC;
              cnt   <= dec.word ? 7'(DIV_ITER_W) : 7'(DIV_ITER_D);
            end
          end
        end
        CALC: begin
          rem_q  <= step_rem;
          quot_q <= step_quot;
          cnt    <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            state    <= DONE;
            o_vld    <= 1'b1;
            o_result <= fin_res;
          end
        end
        DONE: begin
          if (i_rdy) begin
            state <= IDLE;
            o_vld <= 1'b0;
            o_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_unit.sv
// tb/tb_mdu_div_unit.sv - scoreboard testbench for mdu_div_unit
module tb_mdu_div_unit;

  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_DIVW  = 5'b10001;
  localparam logic [4:0] OP_DIVU  = 5'b10010;
  localparam logic [4:0] OP_REM   = 5'b10011;
  localparam logic [4:0] OP_REMW  = 5'b10100;
  localparam logic [4:0] OP_REMU  = 5'b10101;
  localparam logic [4:0] OP_REMUW = 5'b10110;
  localparam logic [4:0] OP_BAD   = 5'b00111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        vld = 1'b0;
  logic        rdy_in = 1'b1;
  logic [4:0]  micop = '0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [6:0]  tag = '0;
  logic        o_rdy, o_vld;
  logic [63:0] o_result;
  logic [6:0]  o_tag;

  mdu_div_unit dut (
    .clk      (clk),
    .rst      (rst_n),
    .i_flush  (flush),
    .i_vld    (vld),
    .o_rdy    (o_rdy),
    .i_micop  (micop),
    .i_src1   (src1),
    .i_src2   (src2),
    .i_tag    (tag),
    .o_vld    (o_vld),
    .i_rdy    (rdy_in),
    .o_result (o_result),
    .o_tag    (o_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int n_unexp = 0;

  typedef struct {
    logic [63:0] res;
    logic [6:0]  tag;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  int   rise_cyc = 0;
  logic vld_d = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (o_vld && !vld_d) rise_cyc = cyc;
    vld_d = o_vld;
    if (o_vld && rdy_in) begin
      if (sb.size() == 0) n_unexp++;
      else begin
        e = sb.pop_front();
        check("result", o_result, e.res);
        check("tag", 64'(o_tag), 64'(e.tag));
        check("latency", 64'(rise_cyc - e.acc), 64'(e.lat - 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [6:0] t, input logic [63:0] exp, input int lat, input bit push);
    int guard = 0;
    while (!o_rdy && guard < 300) begin
      tick();
      guard++;
    end
    if (!o_rdy) begin
      check("rdy_timeout", 64'(o_rdy), 64'd1);
      return;
    end
    micop = op; src1 = a; src2 = b; tag = t; vld = 1'b1;
    tick();
    vld = 1'b0;
    if (push) sb.push_back('{res: exp, tag: t, acc: cyc, lat: lat});
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || o_vld) && guard < 300) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    repeat (3) tick();
    check("reset_rdy", 64'(o_rdy), 64'd1);
    check("reset_vld", 64'(o_vld), 64'd0);
    check("reset_result", o_result, 64'd0);
    check("reset_tag", 64'(o_tag), 64'd0);
    rst_n = 1'b1;
    tick();

    issue(OP_DIV,   64'd100, 64'd7, 7'h11, 64'd14, 65, 1'b1); drain();
    issue(OP_REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 7'h12, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1); drain();
    issue(OP_REMU,  64'd100, 64'd7, 7'h13, 64'd2, 65, 1'b1); drain();
    issue(OP_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 7'h14, 64'hFFFF_FFFF_FFFF_FFF2, 65, 1'b1); drain();
    issue(OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 7'h15, 64'h0FFF_FFFF_FFFF_FFFF, 65, 1'b1); drain();
    issue(OP_DIVU,  64'h55, 64'd0, 7'h16, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1); drain();
    issue(OP_REM,   64'h1234, 64'd0, 7'h17, 64'h1234, 1, 1'b1); drain();
    issue(OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 7'h18, 64'h8000_0000_0000_0000, 1, 1'b1); drain();
    issue(OP_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 7'h19, 64'hFFFF_FFFF_8000_0000, 1, 1'b1); drain();
    issue(OP_REMW,  64'h8000_0000, 64'hFFFF_FFFF, 7'h1A, 64'd0, 1, 1'b1); drain();
    issue(OP_DIVW,  64'h1234_5678_FFFF_FFF8, 64'd3, 7'h1B, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b1); drain();
    issue(OP_REMUW, 64'hFFFF_FFFF, 64'd16, 7'h1C, 64'hF, 33, 1'b1); drain();
    issue(OP_BAD,   64'd77, 64'd5, 7'h1D, 64'd0, 1, 1'b1); drain();

    // flush during CALC: nothing completes, the flush-cycle request is dropped
    issue(OP_DIV, 64'd1000, 64'd3, 7'h20, 64'd0, 0, 1'b0);
    repeat (9) tick();
    micop = OP_DIV; src1 = 64'd8; src2 = 64'd2; tag = 7'h21; vld = 1'b1; flush = 1'b1;
    tick();
    vld = 1'b0; flush = 1'b0;
    check("flush_rdy", 64'(o_rdy), 64'd1);
    check("flush_vld", 64'(o_vld), 64'd0);
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (o_vld) vcount++;
    end
    check("flush_no_vld", 64'(vcount), 64'd0);
    issue(OP_DIV, 64'd9, 64'd3, 7'h22, 64'd3, 65, 1'b1); drain();

    // back-pressure in DONE holds the result
    rdy_in = 1'b0;
    issue(OP_DIV, 64'd50, 64'd5, 7'h2A, 64'd10, 65, 1'b1);
    vcount = 0;
    while (!o_vld && vcount < 100) begin
      tick();
      vcount++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_vld", 64'(o_vld), 64'd1);
      check("hold_result", o_result, 64'd10);
      check("hold_tag", 64'(o_tag), 64'h2A);
      check("hold_rdy", 64'(o_rdy), 64'd0);
      tick();
    end
    rdy_in = 1'b1;
    drain();
    tick();
    check("post_hold_rdy", 64'(o_rdy), 64'd1);

    // reset mid-op discards the op and restores reset outputs
    issue(OP_DIVU, 64'd1000, 64'd7, 7'h55, 64'd0, 0, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_vld", 64'(o_vld), 64'd0);
    check("midrst_rdy", 64'(o_rdy), 64'd1);
    check("midrst_result", o_result, 64'd0);
    check("midrst_tag", 64'(o_tag), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (80) tick();

    check("unexpected_results", 64'(n_unexp), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
